// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with forwarding and operand selection.
// Feeds ALUControl/A/B to the ALU and carries mem/wb control onward.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      ID_Valid,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
  input  logic [DATA_WIDTH-1:0]     ID_SignExtImm,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Shamt,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rs,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rt,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rd,
  input  logic [CTRL_WIDTH-1:0]     ID_ALUControl,
  input  logic                      ID_ALUSrc,
  input  logic                      ID_ShiftSel,
  input  logic                      ID_RegDst,
  input  logic                      ID_RegWrite,
  input  logic                      ID_MemRead,
  input  logic                      ID_MemWrite,
  input  logic                      ID_MemToReg,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      MEM_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_WriteReg,
  input  logic [DATA_WIDTH-1:0]     MEM_ALUResult,
  input  logic                      WB_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] WB_WriteReg,
  input  logic [DATA_WIDTH-1:0]     WB_WriteData,
  output logic [CTRL_WIDTH-1:0]     EX_ALUControl,
  output logic [DATA_WIDTH-1:0]     EX_A,
  output logic [DATA_WIDTH-1:0]     EX_B,
  output logic [DATA_WIDTH-1:0]     EX_StoreData,
  output logic [REG_ADDR_WIDTH-1:0] EX_WriteReg,
  output logic                      EX_RegWrite,
  output logic                      EX_MemRead,
  output logic                      EX_MemWrite,
  output logic                      EX_MemToReg,
  output logic                      EX_Valid,
  output logic [1:0]                ForwardA,
  output logic [1:0]                ForwardB,
  output logic                      HazardStall
);

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] shamt;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] wreg;
    logic [CTRL_WIDTH-1:0]     alu;
    logic                      alu_src;
    logic                      shift_sel;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
  } id_ex_t;

  localparam int PAD = DATA_WIDTH - REG_ADDR_WIDTH;

  id_ex_t q;
  id_ex_t cap;

  logic                  load_in_ex;
  logic                  rs_hit;
  logic                  rt_hit;
  logic                  bubble;
  logic                  mem_a;
  logic                  mem_b;
  logic                  wb_a;
  logic                  wb_b;
  logic [DATA_WIDTH-1:0] fwd_rs;
  logic [DATA_WIDTH-1:0] fwd_rt;

  always_comb begin
    cap            = '0;
    cap.valid      = ID_Valid;
    cap.rd1        = ID_ReadData1;
    cap.rd2        = ID_ReadData2;
    cap.imm        = ID_SignExtImm;
    cap.shamt      = ID_Shamt;
    cap.rs         = ID_Rs;
    cap.rt         = ID_Rt;
    cap.wreg       = ID_RegDst ? ID_Rd : ID_Rt;
    cap.alu        = ID_ALUControl;
    cap.alu_src    = ID_ALUSrc;
    cap.shift_sel  = ID_ShiftSel;
    cap.reg_write  = ID_RegWrite;
    cap.mem_read   = ID_MemRead;
    cap.mem_write  = ID_MemWrite;
    cap.mem_to_reg = ID_MemToReg;
  end

  // Rt is compared even for I-type users: conservative but safe.
  assign load_in_ex = q.valid & q.mem_read
                    & (q.wreg != '0);
  assign rs_hit = (ID_Rs == q.wreg);
  assign rt_hit = (ID_Rt == q.wreg);
  assign HazardStall = load_in_ex & ID_Valid
                     & (rs_hit | rt_hit);

  assign bubble = Flush | (~Stall & HazardStall);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else if (!Stall) begin
      q <= cap;
    end
  end

  assign mem_a = MEM_RegWrite & (MEM_WriteReg != '0)
               & (MEM_WriteReg == q.rs);
  assign mem_b = MEM_RegWrite & (MEM_WriteReg != '0)
               & (MEM_WriteReg == q.rt);
  assign wb_a  = WB_RegWrite & (WB_WriteReg != '0)
               & (WB_WriteReg == q.rs);
  assign wb_b  = WB_RegWrite & (WB_WriteReg != '0)
               & (WB_WriteReg == q.rt);

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    ForwardA = 2'b00;
    fwd_rs   = q.rd1;
    if (mem_a) begin
      ForwardA = 2'b10;
      fwd_rs   = MEM_ALUResult;
    end else if (wb_a) begin
      ForwardA = 2'b01;
      fwd_rs   = WB_WriteData;
    end
  end

  always_comb begin
    ForwardB = 2'b00;
    fwd_rt   = q.rd2;
    if (mem_b) begin
      ForwardB = 2'b10;
      fwd_rt   = MEM_ALUResult;
    end else if (wb_b) begin
      ForwardB = 2'b01;
      fwd_rt   = WB_WriteData;
    end
  end

  always_comb begin
    EX_A = fwd_rs;
    EX_B = q.alu_src ? q.imm : fwd_rt;
    if (q.shift_sel) begin
      EX_A = fwd_rt;
      EX_B = {{PAD{1'b0}}, q.shamt};
    end
  end

  assign EX_StoreData  = fwd_rt;
  assign EX_ALUControl = q.alu;
  assign EX_WriteReg   = q.wreg;
  assign EX_RegWrite   = q.reg_write;
  assign EX_MemRead    = q.mem_read;
  assign EX_MemWrite   = q.mem_write;
  assign EX_MemToReg   = q.mem_to_reg;
  assign EX_Valid      = q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage.
// Expected EX-side views are queued at drive time, popped at sample.
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        v;
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic [3:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        hz;
  } out_t;

  localparam logic [6:0] C_R   = 7'b0011000;
  localparam logic [6:0] C_LW  = 7'b1001101;
  localparam logic [6:0] C_SH  = 7'b0111000;
  localparam logic [6:0] C_IMM = 7'b1001000;

  logic        Clk;
  logic        Reset;
  logic        ID_Valid;
  logic [31:0] ID_ReadData1;
  logic [31:0] ID_ReadData2;
  logic [31:0] ID_SignExtImm;
  logic [4:0]  ID_Shamt;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic [4:0]  ID_Rd;
  logic [3:0]  ID_ALUControl;
  logic        ID_ALUSrc;
  logic        ID_ShiftSel;
  logic        ID_RegDst;
  logic        ID_RegWrite;
  logic        ID_MemRead;
  logic        ID_MemWrite;
  logic        ID_MemToReg;
  logic        Stall;
  logic        Flush;
  logic        MEM_RegWrite;
  logic [4:0]  MEM_WriteReg;
  logic [31:0] MEM_ALUResult;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic [3:0]  EX_ALUControl;
  logic [31:0] EX_A;
  logic [31:0] EX_B;
  logic [31:0] EX_StoreData;
  logic [4:0]  EX_WriteReg;
  logic        EX_RegWrite;
  logic        EX_MemRead;
  logic        EX_MemWrite;
  logic        EX_MemToReg;
  logic        EX_Valid;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        HazardStall;

  id_ex_operand_stage dut (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid),
    .ID_ReadData1(ID_ReadData1),
    .ID_ReadData2(ID_ReadData2),
    .ID_SignExtImm(ID_SignExtImm),
    .ID_Shamt(ID_Shamt), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_ALUControl(ID_ALUControl),
    .ID_ALUSrc(ID_ALUSrc), .ID_ShiftSel(ID_ShiftSel),
    .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg),
    .Stall(Stall), .Flush(Flush),
    .MEM_RegWrite(MEM_RegWrite),
    .MEM_WriteReg(MEM_WriteReg),
    .MEM_ALUResult(MEM_ALUResult),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_WriteData(WB_WriteData),
    .EX_ALUControl(EX_ALUControl),
    .EX_A(EX_A), .EX_B(EX_B),
    .EX_StoreData(EX_StoreData),
    .EX_WriteReg(EX_WriteReg),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .EX_MemToReg(EX_MemToReg),
    .EX_Valid(EX_Valid),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .HazardStall(HazardStall)
  );

  int   vectors = 0;
  int   miscompares = 0;
  out_t sb[$];
  out_t exp_o;
  out_t got;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic out_t obs();
    out_t o;
    o.v   = EX_Valid;
    o.alu = EX_ALUControl;
    o.a   = EX_A;
    o.b   = EX_B;
    o.sd  = EX_StoreData;
    o.wr  = EX_WriteReg;
    o.ctl = {EX_RegWrite, EX_MemRead,
             EX_MemWrite, EX_MemToReg};
    o.fa  = ForwardA;
    o.fb  = ForwardB;
    o.hz  = HazardStall;
    return o;
  endfunction

  function automatic out_t mk(
    input logic v, input logic [3:0] alu,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] sd, input logic [4:0] wr,
    input logic [3:0] ctl, input logic [1:0] fa,
    input logic [1:0] fb, input logic hz);
    out_t o;
    o.v = v; o.alu = alu; o.a = a; o.b = b;
    o.sd = sd; o.wr = wr; o.ctl = ctl;
    o.fa = fa; o.fb = fb; o.hz = hz;
    return o;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic id_clear();
    ID_Valid = 0; ID_ReadData1 = 0; ID_ReadData2 = 0;
    ID_SignExtImm = 0; ID_Shamt = 0;
    ID_Rs = 0; ID_Rt = 0; ID_Rd = 0; ID_ALUControl = 0;
    ID_ALUSrc = 0; ID_ShiftSel = 0; ID_RegDst = 0;
    ID_RegWrite = 0; ID_MemRead = 0;
    ID_MemWrite = 0; ID_MemToReg = 0;
    Stall = 0; Flush = 0;
  endtask

  task automatic fwd_clear();
    MEM_RegWrite = 0; MEM_WriteReg = 0; MEM_ALUResult = 0;
    WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 0;
  endtask

  task automatic id_set(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [31:0] r1,
    input logic [31:0] r2, input logic [31:0] imm,
    input logic [4:0] sh, input logic [3:0] alu,
    input logic [6:0] c);
    ID_Valid = 1; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
    ID_ReadData1 = r1; ID_ReadData2 = r2;
    ID_SignExtImm = imm; ID_Shamt = sh;
    ID_ALUControl = alu;
    {ID_ALUSrc, ID_ShiftSel, ID_RegDst, ID_RegWrite,
     ID_MemRead, ID_MemWrite, ID_MemToReg} = c;
  endtask

  task automatic test_reset();
    Reset = 1; id_clear(); fwd_clear();
    #2;
    sb.push_back('0);
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL reset_init got=%h exp=%h", got, exp_o); end
    @(negedge Clk); Reset = 0;
    id_set(1, 8, 0, 32'h100, 32'h3, 32'h10, 0, 0, C_LW);
    step();
    id_set(8, 1, 9, 32'h55, 32'h100, 0, 0, 0, C_R);
    #1;
    sb.push_back(mk(1, 0, 32'h100, 32'h10, 32'h3, 8,
                    4'b1101, 0, 0, 1));
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL reset_pre got=%h exp=%h", got, exp_o); end
    #1; Reset = 1; #1;
    sb.push_back('0);
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL reset_async got=%h exp=%h", got, exp_o); end
    @(negedge Clk); Reset = 0; id_clear();
    step();
  endtask

  task automatic test_add();
    id_set(1, 2, 3, 5, 7, 0, 0, 0, C_R);
    sb.push_back(mk(1, 0, 5, 7, 7, 3, 4'b1000, 0, 0, 0));
    step();
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL add got=%h exp=%h", got, exp_o); end
    id_clear();
  endtask

  task automatic test_forward();
    id_set(4, 6, 5, 32'h11, 32'h22, 0, 0, 0, C_R);
    step();
    MEM_RegWrite = 1; MEM_WriteReg = 4; MEM_ALUResult = 32'hAA;
    WB_RegWrite = 1; WB_WriteReg = 4; WB_WriteData = 32'hBB;
    sb.push_back(mk(1, 0, 32'hAA, 32'h22, 32'h22, 5,
                    4'b1000, 2'b10, 2'b00, 0));
    #1;
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL fwd_mem_over_wb got=%h exp=%h", got, exp_o); end
    MEM_WriteReg = 6;
    sb.push_back(mk(1, 0, 32'hBB, 32'hAA, 32'hAA, 5,
                    4'b1000, 2'b01, 2'b10, 0));
    #1;
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL fwd_split got=%h exp=%h", got, exp_o); end
    fwd_clear();
    id_set(0, 6, 7, 0, 32'h22, 0, 0, 0, C_R);
    step();
    MEM_RegWrite = 1; MEM_WriteReg = 0; MEM_ALUResult = 32'hCC;
    WB_RegWrite = 1; WB_WriteReg = 0; WB_WriteData = 32'hDD;
    sb.push_back(mk(1, 0, 0, 32'h22, 32'h22, 7,
                    4'b1000, 2'b00, 2'b00, 0));
    #1;
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL fwd_r0 got=%h exp=%h", got, exp_o); end
    fwd_clear(); id_clear();
  endtask

  task automatic test_load_use();
    id_set(1, 8, 0, 32'h100, 32'h3, 32'h10, 0, 0, C_LW);
    step();
    id_set(8, 1, 9, 32'h55, 32'h100, 0, 0, 0, C_R);
    sb.push_back(mk(1, 0, 32'h100, 32'h10, 32'h3, 8,
                    4'b1101, 0, 0, 1));
    #1;
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL lu_detect got=%h exp=%h", got, exp_o); end
    sb.push_back('0);
    step();
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL lu_bubble got=%h exp=%h", got, exp_o); end
    sb.push_back(mk(1, 0, 32'h55, 32'h100, 32'h100, 9,
                    4'b1000, 0, 0, 0));
    step();
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL lu_resume got=%h exp=%h", got, exp_o); end
    id_set(1, 0, 0, 32'h100, 32'h3, 32'h10, 0, 0, C_LW);
    step();
    id_set(0, 0, 9, 0, 0, 0, 0, 0, C_R);
    sb.push_back(mk(1, 0, 32'h100, 32'h10, 32'h3, 0,
                    4'b1101, 0, 0, 0));
    #1;
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL lu_r0 got=%h exp=%h", got, exp_o); end
    id_clear();
    step();
  endtask

  task automatic test_shift_imm();
    id_set(0, 5, 2, 32'h999, 32'h1, 0, 3, 7, C_SH);
    sb.push_back(mk(1, 7, 32'h1, 32'h3, 32'h1, 2,
                    4'b1000, 0, 0, 0));
    step();
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL sll got=%h exp=%h", got, exp_o); end
    MEM_RegWrite = 1; MEM_WriteReg = 5; MEM_ALUResult = 32'h40;
    sb.push_back(mk(1, 7, 32'h40, 32'h3, 32'h40, 2,
                    4'b1000, 2'b00, 2'b10, 0));
    #1;
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL sll_fwd got=%h exp=%h", got, exp_o); end
    fwd_clear();
    id_set(1, 4, 0, 32'h20, 32'h77, 32'hFFFFFFFC, 0, 0, C_IMM);
    sb.push_back(mk(1, 0, 32'h20, 32'hFFFFFFFC, 32'h77, 4,
                    4'b1000, 0, 0, 0));
    step();
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL addi got=%h exp=%h", got, exp_o); end
    id_clear();
  endtask

  task automatic test_flush_stall();
    out_t sub_o;
    id_set(1, 2, 3, 5, 7, 0, 0, 0, C_R);
    step();
    id_set(10, 11, 12, 32'h1000, 32'h234, 0, 0, 1, C_R);
    Stall = 1; Flush = 1;
    sb.push_back('0);
    step();
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL flush_stall got=%h exp=%h", got, exp_o); end
    Stall = 0; Flush = 0;
    sub_o = mk(1, 1, 32'h1000, 32'h234, 32'h234, 12,
               4'b1000, 0, 0, 0);
    sb.push_back(sub_o);
    step();
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL sub got=%h exp=%h", got, exp_o); end
    Stall = 1;
    id_set(13, 14, 15, 32'h9, 32'h8, 0, 0, 3, C_R);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(sub_o);
      step();
      exp_o = sb.pop_front(); got = obs(); vectors++;
      if (got !== exp_o) begin miscompares++;
        $display("FAIL stall_hold%0d got=%h exp=%h",
                 i, got, exp_o); end
    end
    Stall = 0;
    id_set(1, 8, 0, 32'h100, 32'h3, 32'h10, 0, 0, C_LW);
    step();
    id_set(8, 1, 9, 32'h55, 32'h100, 0, 0, 0, C_R);
    Stall = 1;
    sb.push_back(mk(1, 0, 32'h100, 32'h10, 32'h3, 8,
                    4'b1101, 0, 0, 1));
    step();
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL stall_hz_hold got=%h exp=%h", got, exp_o); end
    Stall = 0;
    sb.push_back('0);
    step();
    exp_o = sb.pop_front(); got = obs(); vectors++;
    if (got !== exp_o) begin miscompares++;
      $display("FAIL stall_hz_bubble got=%h exp=%h", got, exp_o); end
    id_clear();
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rs, rt, rd;
    logic [31:0] r1, r2, imm;
    logic [3:0]  alu;
    logic        src;
    for (int i = 0; i < 8; i++) begin
      rs  = 5'($urandom_range(1, 31));
      rt  = 5'($urandom_range(1, 31));
      rd  = 5'($urandom_range(1, 31));
      r1  = $urandom; r2 = $urandom; imm = $urandom;
      alu = 4'($urandom_range(0, 9));
      src = 1'($urandom_range(0, 1));
      id_set(rs, rt, rd, r1, r2, imm, 0, alu,
             src ? 7'b1011000 : C_R);
      sb.push_back(mk(1, alu, r1, src ? imm : r2, r2, rd,
                      4'b1000, 0, 0, 0));
      step();
      exp_o = sb.pop_front(); got = obs(); vectors++;
      if (got !== exp_o) begin miscompares++;
        $display("FAIL b2b%0d got=%h exp=%h", i, got, exp_o); end
    end
    id_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_shift_imm();
    test_flush_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register plus operand-delivery logic feeding the 32-bit ALU in the pipelined SAD datapath. Captures decoded operands and control from ID, resolves EX/MEM and MEM/WB forwarding, and selects final ALU inputs A/B (register, immediate, or shamt). Detects load-use hazards and inserts bubbles. Drives ALUControl, A, B directly into the ALU and carries memory/writeback control to EX/MEM.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_ADDR_WIDTH, 5, register specifier width
CTRL_WIDTH, 4, ALU control code width

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
ID_Valid  input  1  ID holds a real instruction
ID_ReadData1  input  32  rs value from register file
ID_ReadData2  input  32  rt value from register file
ID_SignExtImm  input  32  sign-extended immediate
ID_Shamt  input  5  shift amount field
ID_Rs, ID_Rt, ID_Rd  input  5 each  register specifiers
ID_ALUControl  input  4  ALU op code (0=add … 9=not-equal)
ID_ALUSrc  input  1  1: B = immediate
ID_ShiftSel  input  1  1: A = rt, B = zero-extended shamt (sll/srl)
ID_RegDst  input  1  1: dest = rd, 0: dest = rt
ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg  input  1 each  downstream control
Stall  input  1  downstream hold request
Flush  input  1  squash ID instruction (taken branch)
MEM_RegWrite  input  1  EX/MEM writes a register
MEM_WriteReg  input  5  EX/MEM destination
MEM_ALUResult  input  32  EX/MEM ALU result
WB_RegWrite  input  1  MEM/WB writes a register
WB_WriteReg  input  5  MEM/WB destination
WB_WriteData  input  32  MEM/WB writeback value
EX_ALUControl  output  4  to ALU
EX_A, EX_B  output  32 each  to ALU
EX_StoreData  output  32  forwarded rt for sw
EX_WriteReg  output  5  resolved destination
EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_Valid  output  1 each  registered control
ForwardA, ForwardB  output  2 each  00 regfile, 01 WB, 10 MEM (rs / rt paths)
HazardStall  output  1  load-use: freeze PC and IF/ID

Behaviour:
- Reset (async, active-high): all registered fields 0; EX_Valid/controls/EX_ALUControl/EX_WriteReg = 0; EX_A/EX_B/EX_StoreData = 0 when no forward hits; HazardStall = 0 immediately.
- Per rising edge, priority: Flush -> bubble; else Stall -> hold all registers; else HazardStall -> bubble; else capture ID fields, with EX_WriteReg = RegDst ? Rd : Rt.
- Bubble: Valid, RegWrite, MemRead, MemWrite, MemToReg, ALUControl, WriteReg = 0; data fields cleared to 0.
- HazardStall (combinational) = EX_Valid & EX_MemRead & EX_WriteReg != 0 & ID_Valid & (ID_Rs == EX_WriteReg | ID_Rt == EX_WriteReg). Rt compared unconditionally (conservative). Stall and HazardStall together: hold wins, HazardStall stays asserted.
- Forwarding (combinational on registered Rs/Rt), per path: MEM hit (MEM_RegWrite, MEM_WriteReg != 0, match) -> MEM_ALUResult, code 10; else WB hit -> WB_WriteData, code 01; else registered regfile value, code 00. MEM beats WB. Register 0 never forwarded.
- fwdRs/fwdRt = forwarded values. EX_A = ShiftSel ? fwdRt : fwdRs. EX_B = ShiftSel ? {27'b0, Shamt} : (ALUSrc ? Imm : fwdRt). EX_StoreData = fwdRt.
- Latency: ID -> EX outputs one cycle. Forward muxes follow MEM/WB inputs in the same cycle.
- Same-cycle WB write with ID read: handled by the register file (write-first); this block does not bypass ID.

Test Plan:
- Reset mid-operation: load add, assert Reset between edges -> EX_Valid=0, EX_RegWrite=0, HazardStall=0 without a clock edge.
- add $3,$1,$2 (R1=5, R2=7), no hazards -> next cycle EX_A=5, EX_B=7, EX_ALUControl=0, EX_WriteReg=3, ForwardA=ForwardB=00.
- EX Rs=4, MEM_WriteReg=4 (0xAA) and WB_WriteReg=4 (0xBB) both writing -> EX_A=0xAA, ForwardA=10. With MEM_WriteReg=0 and regfile value 0 -> no forward, ForwardA=00.
- lw $8 in EX, ID add $9,$8,$1 -> HazardStall=1; next edge EX_Valid=0 and all controls 0; following edge add captured, EX_Valid=1.
- sll $2,$5,3 (R5=0x1), ShiftSel=1 -> EX_A=0x1, EX_B=3. addi imm=-4 -> EX_B=0xFFFFFFFC.
- Flush and Stall both asserted -> bubble captured. Stall alone for 3 cycles -> outputs unchanged.
